// File: rtl/relu_stream_unit_if.sv
// Valid/ready stream bundle for the activation stage: upstream beat in, activated beat out.
// slave is the unit's view; master is the producer/consumer side.
interface relu_stream_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;
    logic                      out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/relu_stream_unit.sv
// Two-stage pipelined multi-lane activation (pass / ReLU / leaky / clipped) on a valid/ready stream,
// with a saturating count of lanes clipped in clipped-ReLU mode.
module relu_lane #(
    parameter int DATA_W     = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] clip_val,
    output logic signed [DATA_W-1:0] y,
    output logic                     clipped
);
    logic neg;
    assign neg     = x[DATA_W-1];
    assign clipped = !neg && (x > clip_val);

    // Every branch is either x, 0, clip_val or a right shift of x, so nothing can overflow.
    always_comb begin
        y = x;
        case (mode)
            2'd1: if (neg) y = '0;
            2'd2: if (neg) y = x >>> LEAK_SHIFT;
            2'd3: begin
                if (neg)          y = '0;
                else if (clipped) y = clip_val;
            end
            default: y = x;
        endcase
    end
endmodule

module relu_stream_unit #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] clip_val,
    input  logic                     clr_count,
    output logic [CNT_W-1:0]         clip_count,
    relu_stream_if.slave             s
);
    localparam int PW = $clog2(LANES + 1);

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    logic                      s1_valid, s2_valid;
    logic                      s1_last, s2_last;
    vec_t                      s1_data, s2_data, act;
    logic [1:0]                s1_mode;
    logic signed [DATA_W-1:0]  s1_clip;
    logic [LANES-1:0]          lane_clip;
    logic                      s1_adv, s2_adv, s2_load;
    logic [PW-1:0]             n_clip;
    logic [CNT_W:0]            cnt_sum;

    assign s2_adv  = !s2_valid || s.out_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign s2_load = s2_adv && s1_valid;

    assign s.in_ready  = s1_adv;
    assign s.out_valid = s2_valid;
    assign s.out_data  = s2_data;
    assign s.out_last  = s2_last;

    // mode/clip_val travel with the beat so in-flight data is unaffected by later changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_clip  <= '0;
        end else if (s1_adv) begin
            s1_valid <= s.in_valid;
            if (s.in_valid) begin
                s1_data <= s.in_data;
                s1_last <= s.in_last;
                s1_mode <= mode;
                s1_clip <= clip_val;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_lane #(.DATA_W(DATA_W), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
            .mode     (s1_mode),
            .x        (s1_data[i]),
            .clip_val (s1_clip),
            .y        (act[i]),
            .clipped  (lane_clip[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act;
                s2_last <= s1_last;
            end
        end
    end

    always_comb begin
        n_clip = '0;
        for (int i = 0; i < LANES; i++) n_clip = n_clip + PW'(lane_clip[i]);
    end

    assign cnt_sum = {1'b0, clip_count} + (CNT_W+1)'(n_clip);

    // A carry out of the sum means the true total passed the maximum: pin it there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip_count <= '0;
        else if (clr_count)
            clip_count <= '0;
        else if (s2_load && s1_mode == 2'd3)
            clip_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_relu_stream_unit.sv
// Scoreboard bench for relu_stream_unit: a driver pushes model results per accepted beat,
// a negedge monitor pops and compares every delivered beat.
module tb_relu_stream_unit;
    localparam int DATA_W     = 16;
    localparam int LANES      = 4;
    localparam int LEAK_SHIFT = 3;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic [LANES*DATA_W-1:0] data;
        logic                    last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          mode;
    logic [DATA_W-1:0]   clip_val;
    logic                clr_count;
    logic [CNT_W-1:0]    clip_count;

    relu_stream_if #(.DATA_W(DATA_W), .LANES(LANES)) sif ();

    relu_stream_unit #(.DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .clip_val   (clip_val),
        .clr_count  (clr_count),
        .clip_count (clip_count),
        .s          (sif)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    exp_count = 0;
    int    n_acc = 0;
    beat_t sb_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Activation straight from the arithmetic definition; leaky uses floor division.
    function automatic int ref_act(int x, int m, int c);
        int d;
        int q;
        d = 1 << LEAK_SHIFT;
        if (m == 0) return x;
        if (m == 1) return (x < 0) ? 0 : x;
        if (m == 2) begin
            if (x >= 0) return x;
            q = x / d;
            if (q * d != x) q = q - 1;
            return q;
        end
        if (x < 0) return 0;
        return (x > c) ? c : x;
    endfunction

    function automatic logic [63:0] pack4(int a, int b, int c, int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic push_exp(logic [63:0] d, logic last, int m, int c);
        beat_t b;
        int    x;
        int    y;
        int    nclip;
        nclip  = 0;
        b.last = last;
        b.data = '0;
        for (int i = 0; i < LANES; i++) begin
            x = $signed(d[i*DATA_W +: DATA_W]);
            y = ref_act(x, m, c);
            b.data[i*DATA_W +: DATA_W] = 16'(y);
            if (m == 3 && x > c) nclip++;
        end
        if (m == 3) exp_count = (exp_count + nclip > CNT_MAX) ? CNT_MAX : exp_count + nclip;
        sb_q.push_back(b);
    endtask

    task automatic send_beat(logic [63:0] d, logic last, int m, int c);
        logic acc;
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_last  = last;
        mode         = 2'(m);
        clip_val     = 16'(c);
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = sif.in_ready;
            @(posedge clk);
            #1;
        end
        if (acc) begin
            n_acc++;
            push_exp(d, last, m, c);
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
    endtask

    task automatic idle();
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    task automatic drain();
        idle();
        sif.out_ready = 1'b1;
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop/compare on every transfer; also enforce hold-stable while stalled.
    initial begin
        logic        held;
        logic [63:0] hd;
        logic        hl;
        beat_t       e;
        held = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_valid", 64'(sif.out_valid), 64'd1);
                    check("stall_data", sif.out_data, hd);
                    check("stall_last", 64'(sif.out_last), 64'(hl));
                end
                held = sif.out_valid && !sif.out_ready;
                hd   = sif.out_data;
                hl   = sif.out_last;
                if (sif.out_valid && sif.out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat got=%0h exp=none", sif.out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_data", sif.out_data, e.data);
                        check("out_last", 64'(sif.out_last), 64'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        int          base;
        int          seen;
        logic        acc;
        logic        acc_prev;
        logic [63:0] cd;
        logic        cl;
        int          cm;
        int          cc;
        int          lv[LANES];

        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.in_last   = 1'b0;
        sif.out_ready = 1'b1;
        mode          = 2'd0;
        clip_val      = '0;
        clr_count     = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(sif.out_valid), 64'd0);
        check("rst_out_last", 64'(sif.out_last), 64'd0);
        check("rst_out_data", sif.out_data, 64'd0);
        check("rst_clip_count", 64'(clip_count), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(sif.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ReLU with latency probe
        send_beat(pack4(1000, -1110, 0, 32767), 1'b1, 1, 0);
        idle();
        @(negedge clk);
        check("latency_cycle1_valid", 64'(sif.out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2_valid", 64'(sif.out_valid), 64'd1);
        drain();

        // Leaky, including the most-negative input, then positives and zero
        send_beat(pack4(-1110, -8, -1, -32768), 1'b0, 2, 0);
        send_beat(pack4(5, 32767, 0, 1), 1'b1, 2, 0);
        drain();

        // Clipped ReLU; equal-to-clip lane is not counted
        send_beat(pack4(2000, 1536, -5, 100), 1'b1, 3, 1536);
        drain();
        check("clip_count_t3", 64'(clip_count), 64'(exp_count));

        // Mode change between consecutive beats
        send_beat(pack4(-16, -16, -16, -16), 1'b0, 1, 0);
        send_beat(pack4(-16, -16, -16, -16), 1'b1, 2, 0);
        drain();

        // Backpressure: 5 stalled cycles, 6 beats
        sif.out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_accepts", 64'(n_acc - base), 64'd2);
                check("bp_in_ready", 64'(sif.in_ready), 64'd0);
                sif.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++)
                    send_beat({$urandom, $urandom}, (i == 2 || i == 5), 0, 0);
            end
        join
        drain();

        // Randomized mix of modes, edge values, valid gaps and output stalls
        acc_prev = 1'b1;
        cd = '0; cl = 1'b0; cm = 0; cc = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!sif.in_valid || acc_prev) begin
                if ($urandom_range(0, 3) != 0) begin
                    cm = int'($urandom_range(0, 3));
                    cc = int'($urandom_range(0, 32767));
                    for (int i = 0; i < LANES; i++) begin
                        case ($urandom_range(0, 5))
                            0:       lv[i] = 0;
                            1:       lv[i] = -32768;
                            2:       lv[i] = 32767;
                            3:       lv[i] = cc;
                            4:       lv[i] = cc + 1;
                            default: lv[i] = int'($urandom_range(0, 65535)) - 32768;
                        endcase
                    end
                    cd = pack4(lv[0], lv[1], lv[2], lv[3]);
                    cl = 1'($urandom_range(0, 1));
                    sif.in_valid = 1'b1;
                    sif.in_data  = cd;
                    sif.in_last  = cl;
                    mode         = 2'(cm);
                    clip_val     = 16'(cc);
                end else begin
                    idle();
                end
            end
            sif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = sif.in_valid && sif.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                push_exp(cd, cl, cm, cc);
            end
            acc_prev = acc;
        end
        drain();
        check("clip_count_random", 64'(clip_count), 64'(exp_count));

        // Reset with two clipping beats in flight
        send_beat(pack4(100, 100, 100, 100), 1'b0, 3, 10);
        send_beat(pack4(100, 100, 100, 100), 1'b1, 3, 10);
        rst_n = 1'b0;
        sb_q.delete();
        exp_count = 0;
        idle();
        #1;
        check("midrst_out_valid", 64'(sif.out_valid), 64'd0);
        check("midrst_clip_count", 64'(clip_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (sif.out_valid) seen++;
        end
        check("midrst_no_emit", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Saturation: 4 clipped lanes per beat drives the count past its maximum
        for (int i = 0; i < 16390; i++)
            send_beat(pack4(1, 1, 1, 1), 1'b0, 3, 0);
        drain();
        check("clip_count_sat", 64'(clip_count), 64'(exp_count));

        // Clear coinciding with the S2 load of a clipping beat
        send_beat(pack4(9, 9, 9, 9), 1'b1, 3, 0);
        idle();
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        exp_count = 0;
        check("clip_count_clr", 64'(clip_count), 64'(exp_count));
        drain();
        check("clip_count_after_clr", 64'(clip_count), 64'(exp_count));
        send_beat(pack4(9, 9, -9, 0), 1'b1, 3, 0);
        drain();
        check("clip_count_resume", 64'(clip_count), 64'(exp_count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
